lcd_refresh_ctrl: RTL and testbench

LCD_REFRESH_CTRL -- requirements
Module: lcd_refresh_ctrl

---
 rtl/lcd_refresh_ctrl_if.sv | 17 +
 rtl/lcd_refresh_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_lcd_refresh_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_refresh_ctrl_if.sv
// Pin bundle between the refresh controller and an HD44780-style character LCD.
interface lcd_refresh_ctrl_if;
  logic       LCD_ON;
  logic       LCD_BLON;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;
  logic [7:0] LCD_DATA;

  modport master (
    output LCD_ON, LCD_BLON, LCD_RW, LCD_EN, LCD_RS, LCD_DATA
  );

  modport slave (
    input LCD_ON, LCD_BLON, LCD_RW, LCD_EN, LCD_RS, LCD_DATA
  );
endinterface

// File: rtl/lcd_refresh_ctrl.sv
// 16x2 character LCD controller: power-up delay, init sequence, then 34-write frames on request.
// Optional LCD_AUTO_REFRESH_EN adds a periodic frame request counted from the end of init.
module lcd_refresh_ctrl #(
  parameter int unsigned EN_PULSE_CYC     = 16,
  parameter int unsigned CMD_WAIT_CYC     = 2500,
  parameter int unsigned CLEAR_WAIT_CYC   = 100000,
  parameter int unsigned POWERUP_WAIT_CYC = 1000000,
  parameter int unsigned REFRESH_CYC      = 2500000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [127:0]       letters_LCD_one,
  input  logic [127:0]       letters_LCD_two,
  input  logic               update,
  output logic               busy,
  output logic               frame_done,
  lcd_refresh_ctrl_if.master lcd
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxWait = max2(max2(EN_PULSE_CYC, CMD_WAIT_CYC),
                                         max2(CLEAR_WAIT_CYC, POWERUP_WAIT_CYC));
  localparam int unsigned CntW    = $clog2(MaxWait + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t       PulseLast    = cnt_t'(EN_PULSE_CYC - 1);
  localparam cnt_t       CmdLast      = cnt_t'(CMD_WAIT_CYC - 1);
  localparam cnt_t       ClearLast    = cnt_t'(CLEAR_WAIT_CYC - 1);
  localparam cnt_t       PowerupLast  = cnt_t'(POWERUP_WAIT_CYC - 1);
  localparam logic [5:0] InitLastIdx  = 6'd3;
  localparam logic [5:0] FrameLastIdx = 6'd33;

  typedef enum logic [1:0] {StPowerup, StInit, StIdle, StFrame} state_e;
  typedef enum logic [1:0] {PhSetup, PhPulse, PhWait} phase_e;

  state_e       state_q, state_d;
  phase_e       phase_q, phase_d;
  logic [5:0]   idx_q, idx_d;
  cnt_t         cnt_q, cnt_d;
  logic [7:0]   data_q, data_d;
  logic         rs_q, rs_d;
  logic         pend_q, pend_d;
  logic [127:0] row0_q, row0_d;
  logic [127:0] row1_q, row1_d;

  logic       req;
  logic       init_end;
  logic       start;
  logic       writing;
  logic       last_idx;
  cnt_t       wait_last;
  logic [8:0] next_word;

  // {rs, data} for each init command
  function automatic logic [8:0] init_word(input logic [1:0] idx);
    logic [8:0] w;
    unique case (idx)
      2'd0: w = {1'b0, 8'h38};
      2'd1: w = {1'b0, 8'h0C};
      2'd2: w = {1'b0, 8'h01};
      2'd3: w = {1'b0, 8'h06};
    endcase
    return w;
  endfunction

  // {rs, data} for write idx of a frame: 0x80, row 0, 0xC0, row 1
  function automatic logic [8:0] frame_word(input logic [5:0]   idx,
                                            input logic [127:0] r0,
                                            input logic [127:0] r1);
    logic [8:0] w;
    logic [3:0] col0;
    logic [3:0] col1;
    col0 = 4'(idx - 6'd1);
    col1 = 4'(idx - 6'd18);
    if (idx == 6'd0) begin
      w = {1'b0, 8'h80};
    end else if (idx < 6'd17) begin
      w = {1'b1, r0[{col0, 3'b000} +: 8]};
    end else if (idx == 6'd17) begin
      w = {1'b0, 8'hC0};
    end else begin
      w = {1'b1, r1[{col1, 3'b000} +: 8]};
    end
    return w;
  endfunction

`ifdef LCD_AUTO_REFRESH_EN
  localparam int unsigned RefW = $clog2(REFRESH_CYC + 1);

  typedef logic [RefW-1:0] ref_t;

  localparam ref_t RefLast = ref_t'(REFRESH_CYC - 1);

  ref_t ref_cnt_q, ref_cnt_d;
  logic ref_on_q, ref_on_d;
  logic refresh_tick;

  assign refresh_tick = ref_on_q && (ref_cnt_q == RefLast);

  always_comb begin
    ref_cnt_d = ref_cnt_q;
    ref_on_d  = ref_on_q;
    if (init_end) begin
      ref_on_d  = 1'b1;
      ref_cnt_d = '0;
    end else if (ref_on_q) begin
      ref_cnt_d = refresh_tick ? '0 : ref_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ref_cnt_q <= '0;
      ref_on_q  <= 1'b0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      ref_on_q  <= ref_on_d;
    end
  end
`else
  logic refresh_tick;
  assign refresh_tick = 1'b0;
`endif

  assign req     = update | refresh_tick;
  assign writing = (state_q == StInit) || (state_q == StFrame);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    rs_d       = rs_q;
    pend_d     = pend_q;
    row0_d     = row0_q;
    row1_d     = row1_q;
    frame_done = 1'b0;
    init_end   = 1'b0;
    start      = 1'b0;
    last_idx   = (state_q == StInit) ? (idx_q == InitLastIdx) : (idx_q == FrameLastIdx);
    wait_last  = (!rs_q && (data_q == 8'h01)) ? ClearLast : CmdLast;
    next_word  = (state_q == StInit) ? init_word(2'(idx_q + 6'd1))
                                     : frame_word(idx_q + 6'd1, row0_q, row1_q);

    // Requests while busy coalesce into a single pending frame
    if (req && (state_q != StIdle)) pend_d = 1'b1;

    unique case (state_q)
      StPowerup: begin
        if (cnt_q == PowerupLast) begin
          state_d          = StInit;
          phase_d          = PhSetup;
          idx_d            = '0;
          cnt_d            = '0;
          {rs_d, data_d}   = init_word(2'd0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: start = req;
      StInit, StFrame: begin
        unique case (phase_q)
          PhSetup: begin
            phase_d = PhPulse;
            cnt_d   = '0;
          end
          PhPulse: begin
            if (cnt_q == PulseLast) begin
              phase_d = PhWait;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          PhWait: begin
            if (cnt_q == wait_last) begin
              if (last_idx) begin
                if (state_q == StInit) init_end = 1'b1;
                else                   frame_done = 1'b1;
                start = pend_q || req;
                if (!start) begin
                  state_d = StIdle;
                  cnt_d   = '0;
                end
              end else begin
                idx_d          = idx_q + 6'd1;
                phase_d        = PhSetup;
                cnt_d          = '0;
                {rs_d, data_d} = next_word;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase

    // Frame entry: snapshot both rows and present the 0x80 command in the next cycle
    if (start) begin
      state_d = StFrame;
      phase_d = PhSetup;
      idx_d   = '0;
      cnt_d   = '0;
      rs_d    = 1'b0;
      data_d  = 8'h80;
      row0_d  = letters_LCD_one;
      row1_d  = letters_LCD_two;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StPowerup;
      phase_q <= PhSetup;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      pend_q  <= 1'b0;
      row0_q  <= '0;
      row1_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      pend_q  <= pend_d;
      row0_q  <= row0_d;
      row1_q  <= row1_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign lcd.LCD_ON   = 1'b1;
  assign lcd.LCD_BLON = 1'b1;
  assign lcd.LCD_RW   = 1'b0;
  assign lcd.LCD_EN   = writing && (phase_q == PhPulse);
  assign lcd.LCD_RS   = rs_q;
  assign lcd.LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Scoreboard bench for lcd_refresh_ctrl: expected writes are queued by the stimulus thread and
// popped by a monitor on every LCD_EN rising edge; timing is checked from recorded cycle stamps.
module tb_lcd_refresh_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         update = 1'b0;
  logic [127:0] row0;
  logic [127:0] row1;
  logic         busy;
  logic         frame_done;

  lcd_refresh_ctrl_if lcd ();

  lcd_refresh_ctrl #(
    .EN_PULSE_CYC    (2),
    .CMD_WAIT_CYC    (4),
    .CLEAR_WAIT_CYC  (8),
    .POWERUP_WAIT_CYC(10),
    .REFRESH_CYC     (500)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .letters_LCD_one(row0),
    .letters_LCD_two(row1),
    .update         (update),
    .busy           (busy),
    .frame_done     (frame_done),
    .lcd            (lcd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] exp_q[$];
  int         rise_cyc[$];
  int         fd_cyc = 0;
  int         fd_count = 0;
  int         total = 0;
  int         bad = 0;
  logic       prev_en = 1'b0;
  logic       prev_fd = 1'b0;
  logic [8:0] cur_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: one scoreboard pop per EN rise, RS/DATA hold while EN high and in the fall cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (lcd.LCD_EN && !prev_en) begin
          rise_cyc.push_back(cyc);
          cur_word = {lcd.LCD_RS, lcd.LCD_DATA};
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got %0h want none", cur_word);
          end else begin
            check("write_word", 32'(cur_word), 32'(exp_q.pop_front()));
          end
          check("rw_low", 32'(lcd.LCD_RW), 32'd0);
        end else if (lcd.LCD_EN || prev_en) begin
          check("hold_rs_data", 32'({lcd.LCD_RS, lcd.LCD_DATA}), 32'(cur_word));
        end
        if (frame_done) begin
          fd_count++;
          fd_cyc = cyc;
          check("fd_single_cycle", 32'(prev_fd), 32'd0);
        end
      end
      prev_en = lcd.LCD_EN;
      prev_fd = frame_done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_update(output int at);
    update = 1'b1;
    at = cyc;
    step();
    update = 1'b0;
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k = 0;
    while (rise_cyc.size() < n && k < budget) begin
      step();
      k++;
    end
    check("rise_timeout", 32'(rise_cyc.size() >= n), 32'd1);
  endtask

  task automatic wait_fd(input int n, input int budget);
    int k = 0;
    while (fd_count < n && k < budget) begin
      step();
      k++;
    end
    check("frame_done_timeout", 32'(fd_count >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic push_frame(input logic [127:0] r0, input logic [127:0] r1);
    exp_q.push_back({1'b0, 8'h80});
    for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, r0[8*k +: 8]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, r1[8*k +: 8]});
  endtask

  initial begin
    int rel;
    int upd;
    int tmp;
    int base;
    int f0;
    int fd1;
    logic [127:0] row_a;
    logic [127:0] row_b;

    row0 = {16{8'h20}};
    row0[7:0]   = 8'h48;
    row0[15:8]  = 8'h45;
    row0[23:16] = 8'h4C;
    row0[31:24] = 8'h4C;
    row0[39:32] = 8'h4F;
    row1 = {16{8'h2E}};
    for (int k = 0; k < 16; k++) begin
      row_a[8*k +: 8] = 8'(8'h41 + k);
      row_b[8*k +: 8] = 8'(8'h61 + k);
    end

    // Reset state
    reset = 1'b1;
    step();
    step();
    step();
    check("rst_en", 32'(lcd.LCD_EN), 32'd0);
    check("rst_rs", 32'(lcd.LCD_RS), 32'd0);
    check("rst_rw", 32'(lcd.LCD_RW), 32'd0);
    check("rst_data", 32'(lcd.LCD_DATA), 32'h00);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_on", 32'(lcd.LCD_ON), 32'd1);
    check("rst_blon", 32'(lcd.LCD_BLON), 32'd1);

    // Power-up and init sequence
    push_init();
    reset = 1'b0;
    rel = cyc;
    wait_idle(100);
    check("init_busy_fall", 32'(cyc - rel), 32'd42);
    check("init_write_count", 32'(rise_cyc.size()), 32'd4);
    check("init_first_rise", 32'(rise_cyc[0] - rel), 32'd11);
    check("init_gap_38", 32'(rise_cyc[1] - rise_cyc[0]), 32'd7);
    check("init_gap_0c", 32'(rise_cyc[2] - rise_cyc[1]), 32'd7);
    check("init_gap_clear", 32'(rise_cyc[3] - rise_cyc[2]), 32'd11);

    // No frames without an update
    repeat (2000) step();
    check("no_auto_frames", 32'(rise_cyc.size()), 32'd4);

    // Single frame from IDLE
    base = rise_cyc.size();
    f0 = fd_count;
    push_frame(row0, row1);
    pulse_update(upd);
    wait_fd(f0 + 1, 400);
    check("frame_first_rise", 32'(rise_cyc[base] - upd), 32'd2);
    check("frame_len", 32'(fd_cyc - upd), 32'd238);
    step();
    check("frame_done_low", 32'(frame_done), 32'd0);
    check("idle_after_frame", 32'(busy), 32'd0);

    // Three mid-frame updates coalesce into one back-to-back frame
    base = rise_cyc.size();
    f0 = fd_count;
    push_frame(row0, row1);
    push_frame(row0, row1);
    pulse_update(upd);
    wait_rises(base + 3, 100);
    pulse_update(tmp);
    wait_rises(base + 10, 100);
    pulse_update(tmp);
    wait_rises(base + 20, 100);
    pulse_update(tmp);
    wait_fd(f0 + 1, 400);
    fd1 = fd_cyc;
    step();
    check("busy_between_frames", 32'(busy), 32'd1);
    wait_fd(f0 + 2, 400);
    check("back_to_back_rise", 32'(rise_cyc[base + 34] - fd1), 32'd2);
    check("second_frame_len", 32'(fd_cyc - fd1), 32'd238);
    step();
    check("idle_after_pair", 32'(busy), 32'd0);
    repeat (300) step();
    check("coalesced_frames", 32'(fd_count), 32'(f0 + 2));
    check("coalesced_writes", 32'(rise_cyc.size()), 32'(base + 68));

    // Input change mid-frame keeps the snapshot; the next frame carries the new text
    base = rise_cyc.size();
    f0 = fd_count;
    push_frame(row0, row1);
    push_frame(row_a, row_b);
    pulse_update(upd);
    wait_rises(base + 10, 100);
    row0 = row_a;
    row1 = row_b;
    pulse_update(tmp);
    wait_fd(f0 + 2, 700);
    step();
    check("idle_after_snapshot", 32'(busy), 32'd0);
    check("snapshot_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during EN high of write 5 with a pending update
    base = rise_cyc.size();
    f0 = fd_count;
    push_frame(row0, row1);
    pulse_update(upd);
    wait_rises(base + 3, 100);
    pulse_update(tmp);
    wait_rises(base + 5, 100);
    check("abort_en_before", 32'(lcd.LCD_EN), 32'd1);
    reset = 1'b1;
    step();
    check("abort_en", 32'(lcd.LCD_EN), 32'd0);
    check("abort_data", 32'(lcd.LCD_DATA), 32'h00);
    check("abort_busy", 32'(busy), 32'd1);
    exp_q.delete();
    push_init();
    step();
    reset = 1'b0;
    rel = cyc;
    wait_idle(100);
    check("reinit_busy_fall", 32'(cyc - rel), 32'd42);
    check("reinit_first_rise", 32'(rise_cyc[base + 5] - rel), 32'd11);
    repeat (300) step();
    check("no_pending_after_reset", 32'(rise_cyc.size()), 32'(base + 9));
    check("no_frame_done_after_reset", 32'(fd_count), 32'(f0));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
